// File: rtl/cpu_ctrl_seq.sv
// Control sequencer for the 16-bit register-file/ALU datapath.
// Fetches 32-bit instructions over req/ack, decodes them and steps the datapath through EXEC/WB.
module cpu_ctrl_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int unsigned PC_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_data,
    output logic                  reg_write_enable,
    output logic [ADDR_WIDTH-1:0] reg_read_addr1,
    output logic [ADDR_WIDTH-1:0] reg_read_addr2,
    output logic [ADDR_WIDTH-1:0] reg_write_addr,
    output logic [DATA_WIDTH-1:0] reg_write_data,
    output logic [3:0]            alu_comm,
    output logic                  alu_mode,
    output logic                  alu_cin,
    output logic                  b_source_sel,
    output logic [DATA_WIDTH-1:0] alu_b_imm,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_cout,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  busy,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [1:0] OP_RR   = 2'b00;
    localparam logic [1:0] OP_RI   = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] SUB_JMP = 2'b00;
    localparam logic [1:0] SUB_JZ  = 2'b01;
    localparam logic [1:0] SUB_JC  = 2'b10;

    state_t                state, nxt_state;
    logic [PC_WIDTH-1:0]   nxt_pc;
    logic                  nxt_flag_z, nxt_flag_c;
    logic [DATA_WIDTH-1:0] result, nxt_result;

    // Decoded instruction register
    logic [1:0]            ir_op, nxt_ir_op;
    logic [3:0]            ir_comm, nxt_ir_comm;
    logic                  ir_mode, nxt_ir_mode;
    logic                  ir_cin, nxt_ir_cin;
    logic [ADDR_WIDTH-1:0] ir_rd, nxt_ir_rd;
    logic [ADDR_WIDTH-1:0] ir_rs1, nxt_ir_rs1;
    logic [ADDR_WIDTH-1:0] ir_rs2, nxt_ir_rs2;
    logic [15:0]           ir_imm, nxt_ir_imm;

    logic                  nxt_imem_req, nxt_we, nxt_alu_mode, nxt_alu_cin, nxt_b_sel;
    logic [PC_WIDTH-1:0]   nxt_imem_addr;
    logic [ADDR_WIDTH-1:0] nxt_raddr1, nxt_raddr2, nxt_waddr;
    logic [DATA_WIDTH-1:0] nxt_wdata, nxt_b_imm;
    logic [3:0]            nxt_alu_comm;
    logic                  nxt_busy, nxt_halted;
    logic                  taken, exec_alu;

    // Instruction bits [17:16] carry no field
    logic unused_imem_bits;
    assign unused_imem_bits = ^imem_data[17:16];

    always_comb begin
        nxt_state   = state;
        nxt_pc      = pc;
        nxt_flag_z  = flag_z;
        nxt_flag_c  = flag_c;
        nxt_result  = result;
        nxt_ir_op   = ir_op;
        nxt_ir_comm = ir_comm;
        nxt_ir_mode = ir_mode;
        nxt_ir_cin  = ir_cin;
        nxt_ir_rd   = ir_rd;
        nxt_ir_rs1  = ir_rs1;
        nxt_ir_rs2  = ir_rs2;
        nxt_ir_imm  = ir_imm;
        taken       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_state = S_FETCH;
                    nxt_pc    = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    nxt_ir_op   = imem_data[31:30];
                    nxt_ir_comm = imem_data[29:26];
                    nxt_ir_mode = imem_data[25];
                    nxt_ir_cin  = imem_data[24];
                    nxt_ir_rd   = ADDR_WIDTH'(imem_data[23:21]);
                    nxt_ir_rs1  = ADDR_WIDTH'(imem_data[20:18]);
                    nxt_ir_rs2  = ADDR_WIDTH'(imem_data[2:0]);
                    nxt_ir_imm  = imem_data[15:0];
                    nxt_state   = S_DECODE;
                end
            end
            S_DECODE: nxt_state = S_EXEC;
            S_EXEC: begin
                case (ir_op)
                    OP_RR, OP_RI: begin
                        nxt_result = alu_result;
                        nxt_flag_z = (alu_result == '0);
                        nxt_flag_c = alu_cout;
                        nxt_pc     = pc + PC_WIDTH'(1);
                        nxt_state  = S_WB;
                    end
                    OP_LDI: begin
                        nxt_result = DATA_WIDTH'(ir_imm);
                        nxt_pc     = pc + PC_WIDTH'(1);
                        nxt_state  = S_WB;
                    end
                    default: begin
                        case (ir_comm[3:2])
                            SUB_JMP: taken = 1'b1;
                            SUB_JZ:  taken = flag_z;
                            SUB_JC:  taken = flag_c;
                            default: taken = 1'b0;
                        endcase
                        if (ir_comm[3:2] == 2'b11) begin
                            nxt_state = S_HALT;
                        end else begin
                            nxt_pc    = taken ? PC_WIDTH'(ir_imm) : pc + PC_WIDTH'(1);
                            nxt_state = S_FETCH;
                        end
                    end
                endcase
            end
            S_WB: nxt_state = S_FETCH;
            S_HALT: begin
                if (start) begin
                    nxt_state  = S_FETCH;
                    nxt_pc     = '0;
                    nxt_flag_z = 1'b0;
                    nxt_flag_c = 1'b0;
                end
            end
            default: nxt_state = S_IDLE;
        endcase

        // Output values for the coming state, registered below
        exec_alu      = (nxt_state == S_EXEC) && ((nxt_ir_op == OP_RR) || (nxt_ir_op == OP_RI));
        nxt_imem_req  = (nxt_state == S_FETCH);
        nxt_imem_addr = nxt_imem_req ? nxt_pc : '0;
        nxt_raddr1    = ((nxt_state == S_DECODE) || (nxt_state == S_EXEC)) ? nxt_ir_rs1 : '0;
        nxt_raddr2    = ((nxt_state == S_DECODE) || (nxt_state == S_EXEC)) ? nxt_ir_rs2 : '0;
        nxt_we        = (nxt_state == S_WB);
        nxt_waddr     = nxt_we ? nxt_ir_rd : '0;
        nxt_wdata     = nxt_we ? nxt_result : '0;
        nxt_alu_comm  = exec_alu ? nxt_ir_comm : '0;
        nxt_alu_mode  = exec_alu & nxt_ir_mode;
        nxt_alu_cin   = exec_alu & nxt_ir_cin;
        nxt_b_sel     = exec_alu & (nxt_ir_op == OP_RI);
        nxt_b_imm     = exec_alu ? DATA_WIDTH'(nxt_ir_imm) : '0;
        nxt_busy      = (nxt_state == S_FETCH) || (nxt_state == S_DECODE) ||
                        (nxt_state == S_EXEC)  || (nxt_state == S_WB);
        nxt_halted    = (nxt_state == S_HALT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            pc               <= '0;
            flag_z           <= 1'b0;
            flag_c           <= 1'b0;
            result           <= '0;
            ir_op            <= '0;
            ir_comm          <= '0;
            ir_mode          <= 1'b0;
            ir_cin           <= 1'b0;
            ir_rd            <= '0;
            ir_rs1           <= '0;
            ir_rs2           <= '0;
            ir_imm           <= '0;
            imem_req         <= 1'b0;
            imem_addr        <= '0;
            reg_write_enable <= 1'b0;
            reg_read_addr1   <= '0;
            reg_read_addr2   <= '0;
            reg_write_addr   <= '0;
            reg_write_data   <= '0;
            alu_comm         <= '0;
            alu_mode         <= 1'b0;
            alu_cin          <= 1'b0;
            b_source_sel     <= 1'b0;
            alu_b_imm        <= '0;
            busy             <= 1'b0;
            halted           <= 1'b0;
        end else begin
            state            <= nxt_state;
            pc               <= nxt_pc;
            flag_z           <= nxt_flag_z;
            flag_c           <= nxt_flag_c;
            result           <= nxt_result;
            ir_op            <= nxt_ir_op;
            ir_comm          <= nxt_ir_comm;
            ir_mode          <= nxt_ir_mode;
            ir_cin           <= nxt_ir_cin;
            ir_rd            <= nxt_ir_rd;
            ir_rs1           <= nxt_ir_rs1;
            ir_rs2           <= nxt_ir_rs2;
            ir_imm           <= nxt_ir_imm;
            imem_req         <= nxt_imem_req;
            imem_addr        <= nxt_imem_addr;
            reg_write_enable <= nxt_we;
            reg_read_addr1   <= nxt_raddr1;
            reg_read_addr2   <= nxt_raddr2;
            reg_write_addr   <= nxt_waddr;
            reg_write_data   <= nxt_wdata;
            alu_comm         <= nxt_alu_comm;
            alu_mode         <= nxt_alu_mode;
            alu_cin          <= nxt_alu_cin;
            b_source_sel     <= nxt_b_sel;
            alu_b_imm        <= nxt_b_imm;
            busy             <= nxt_busy;
            halted           <= nxt_halted;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: stored program, stubbed ALU, programmable fetch latency.
module tb_cpu_ctrl_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        reg_write_enable;
    logic [2:0]  reg_read_addr1, reg_read_addr2, reg_write_addr;
    logic [15:0] reg_write_data, alu_b_imm, alu_result;
    logic [3:0]  alu_comm;
    logic        alu_mode, alu_cin, b_source_sel, alu_cout;
    logic [7:0]  pc;
    logic        flag_z, flag_c, busy, halted;

    logic [31:0] mem [256];
    int          ack_delay = 1;
    int          ack_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;

    cpu_ctrl_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .reg_write_enable(reg_write_enable), .reg_read_addr1(reg_read_addr1),
        .reg_read_addr2(reg_read_addr2), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .alu_comm(alu_comm), .alu_mode(alu_mode),
        .alu_cin(alu_cin), .b_source_sel(b_source_sel), .alu_b_imm(alu_b_imm),
        .alu_result(alu_result), .alu_cout(alu_cout), .pc(pc),
        .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: acks on the ack_delay-th FETCH cycle, drives a HALT word otherwise
    always @(negedge clk) begin
        if (!imem_req) begin
            ack_cnt   = 0;
            imem_ack  = 1'b0;
            imem_data = 32'hFFFF_FFFF;
        end else begin
            ack_cnt = ack_cnt + 1;
            if (ack_cnt >= ack_delay) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
            end else begin
                imem_ack  = 1'b0;
                imem_data = 32'hFFFF_FFFF;
            end
        end
    end

    function automatic logic [31:0] enc(input logic [1:0] op, input logic [3:0] comm,
                                        input logic mode, input logic cin,
                                        input logic [2:0] rd, input logic [2:0] rs1,
                                        input logic [2:0] rs2, input logic [15:0] imm);
        return {op, comm, mode, cin, rd, rs1, 2'b00, imm} | {29'd0, rs2};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, 64'({imem_req, imem_addr, reg_write_enable, reg_read_addr1,
               reg_read_addr2, reg_write_addr, reg_write_data, alu_comm}), 64'd0);
        check({tag, "_b"}, 64'({alu_mode, alu_cin, b_source_sel, alu_b_imm, pc,
               flag_z, flag_c, busy, halted}), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        alu_result = 16'h0000;
        alu_cout   = 1'b1;
        imem_ack   = 1'b0;
        imem_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
        mem[8'h00] = enc(2'b10, 4'b0000, 1'b0, 1'b0, 3'd1, 3'd0, 3'd0, 16'h1234);
        mem[8'h01] = enc(2'b00, 4'b1001, 1'b0, 1'b1, 3'd3, 3'd1, 3'd2, 16'h0000);
        mem[8'h02] = enc(2'b01, 4'b0000, 1'b0, 1'b0, 3'd4, 3'd1, 3'd0, 16'h00FF);
        mem[8'h03] = enc(2'b11, 4'b0100, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0040);
        mem[8'h04] = enc(2'b11, 4'b0000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0040);
        mem[8'h40] = enc(2'b10, 4'b0000, 1'b0, 1'b0, 3'd2, 3'd0, 3'd0, 16'hBEEF);
        mem[8'h41] = enc(2'b00, 4'b0000, 1'b0, 1'b0, 3'd5, 3'd2, 3'd3, 16'h0000);
        mem[8'h42] = enc(2'b11, 4'b1000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h00FF);
        mem[8'hFF] = enc(2'b10, 4'b0000, 1'b0, 1'b0, 3'd7, 3'd0, 3'd0, 16'h0001);

        #1 check_all_zero("reset");
        #10 reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        step();
        start = 1'b0;

        // LDI r1, 0x1234
        check("fetch0_req", 64'(imem_req), 64'd1);
        check("fetch0_addr", 64'(imem_addr), 64'd0);
        check("fetch0_busy", 64'(busy), 64'd1);
        step(); step(); step();
        check("ldi_wb", 64'({reg_write_enable, reg_write_addr, reg_write_data}), 64'({1'b1, 3'd1, 16'h1234}));
        check("ldi_pc_flags", 64'({pc, flag_z, flag_c}), 64'({8'd1, 2'b00}));
        step();
        check("ldi_we_pulse", 64'(reg_write_enable), 64'd0);
        check("fetch1_addr", 64'(imem_addr), 64'd1);

        // ALU_RR r3 <- r1 op r2, stub result 0 / carry 1
        step();
        check("rr_dec_addr", 64'({reg_read_addr1, reg_read_addr2}), 64'({3'd1, 3'd2}));
        step();
        check("rr_exec_addr", 64'({reg_read_addr1, reg_read_addr2}), 64'({3'd1, 3'd2}));
        check("rr_exec_ctl", 64'({b_source_sel, alu_comm, alu_mode, alu_cin}), 64'({1'b0, 4'b1001, 1'b0, 1'b1}));
        step();
        check("rr_flags", 64'({flag_z, flag_c}), 64'b11);
        check("rr_wb", 64'({reg_write_enable, reg_write_addr, reg_write_data}), 64'({1'b1, 3'd3, 16'h0000}));
        alu_result = 16'h0100;
        alu_cout   = 1'b0;

        // ALU_RI r4 <- r1 op 0x00FF, stub result 0x0100
        step(); step(); step();
        check("ri_exec", 64'({b_source_sel, alu_b_imm, reg_read_addr1}), 64'({1'b1, 16'h00FF, 3'd1}));
        step();
        check("ri_flags", 64'({flag_z, flag_c}), 64'b00);
        check("ri_wb", 64'({reg_write_addr, reg_write_data}), 64'({3'd4, 16'h0100}));
        alu_result = 16'h0000;
        alu_cout   = 1'b1;

        // JZ 0x40 not taken, then JMP 0x40
        step(); step(); step();
        check("jz_exec_quiet", 64'({reg_write_enable, alu_comm, b_source_sel}), 64'd0);
        step();
        check("jz_not_taken", 64'({pc, imem_addr}), 64'({8'h04, 8'h04}));
        step(); step(); step();
        check("jmp_taken", 64'({pc, imem_addr}), 64'({8'h40, 8'h40}));
        ack_delay = 3;

        // Fetch with three-cycle ack latency
        check("lat_c1", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h40}));
        step();
        check("lat_c2", 64'({imem_req, imem_addr, busy}), 64'({1'b1, 8'h40, 1'b1}));
        step();
        check("lat_c3", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h40}));
        step();
        check("lat_dec_req", 64'(imem_req), 64'd0);
        ack_delay = 1;
        step(); step();
        check("lat_ldi_wb", 64'({reg_write_enable, reg_write_addr, reg_write_data}), 64'({1'b1, 3'd2, 16'hBEEF}));

        // ALU_RR at 0x41 sets both flags, JC 0xFF taken
        step(); step(); step(); step();
        check("rr2_flags", 64'({flag_z, flag_c, reg_write_addr}), 64'({2'b11, 3'd5}));
        step(); step(); step(); step();
        check("jc_taken", 64'({pc, imem_addr}), 64'({8'hFF, 8'hFF}));
        mem[8'h00] = enc(2'b11, 4'b1100, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000);

        // LDI at 0xFF wraps pc to 0, which now holds HALT
        step(); step(); step();
        check("wrap_wb", 64'({pc, reg_write_addr, reg_write_data}), 64'({8'h00, 3'd7, 16'h0001}));
        step();
        check("wrap_fetch", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h00}));
        step(); step(); step();
        check("halt_state", 64'({halted, busy, pc}), 64'({1'b1, 1'b0, 8'h00}));
        check("halt_flags", 64'({flag_z, flag_c}), 64'b11);
        step(); step();
        check("halt_hold", 64'({halted, pc, imem_req}), 64'({1'b1, 8'h00, 1'b0}));

        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_flags", 64'({flag_z, flag_c}), 64'b00);
        check("restart_fetch", 64'({imem_req, imem_addr, busy, halted}), 64'({1'b1, 8'h00, 1'b1, 1'b0}));
        step(); step(); step();
        check("halt_again", 64'(halted), 64'd1);

        // Reset asserted during WB
        mem[8'h00] = enc(2'b10, 4'b0000, 1'b0, 1'b0, 3'd1, 3'd0, 3'd0, 16'h1234);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        check("pre_rst_we", 64'(reg_write_enable), 64'd1);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_wb");
        @(negedge clk);
        reset = 1'b1;
        step(); step(); step();
        check("idle_after_rst", 64'({imem_req, busy, halted}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
